seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: number of CP cycles each digit stays active; legal range is 1 to 2^20.
REQ-002 Parameter BLINK_BIT, default 5: the frame-counter bit that sets blink phase; legal range is 0 to 7.
REQ-003 CP  input  1  single clock; all state updates on the rising edge.
REQ-004 nCR  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  scan enable; high means advance.
REQ-006 hour_h, hour_l, min_h, min_l, sec_h, sec_l  input  4 each  BCD digits from the time counters.
REQ-007 blink_sel  input  2  blink field select: 0 = none, 1 = hours, 2 = minutes, 3 = seconds.
REQ-008 AN  output  6  digit enables, active-low; AN[k] drives digit k.
REQ-009 SEG  output  7  segment drives, active-low; bit order is {g,f,e,d,c,b,a}.
REQ-010 DP  output  1  decimal-point drive, active-low.
REQ-011 frame_tick  output  1  one-cycle pulse at each scan wrap.

Function
REQ-012 The prescaler SHALL count 0 to SCAN_DIV-1 while EN=1; its terminal count is the "step" condition.
REQ-013 On each step, the digit index SHALL advance 0→1→…→5→0; a step at index 5 SHALL assert frame_tick for exactly that cycle.
REQ-014 Digit mapping SHALL be: 0 = hour_h, 1 = hour_l, 2 = min_h, 3 = min_l, 4 = sec_h, 5 = sec_l.
REQ-015 AN, SEG and DP SHALL be registered outputs, reflecting the index and input digit sampled one CP edge earlier.
REQ-016 Latency: inputs reach SEG within 1 cycle; the selected digit's value is re-sampled every cycle, not only on steps.
REQ-017 Exactly one AN bit SHALL be low at any time outside reset.
REQ-018 Decode table (SEG) SHALL be:
- 0 → 1000000
- 1 → 1111001
- 2 → 0100100
- 3 → 0110000
- 4 → 0011001
- 5 → 0010010
- 6 → 0000010
- 7 → 1111000
- 8 → 0000000
- 9 → 0010000
REQ-019 Digit values 10 to 15 SHALL display a dash only: SEG = 0111111.
REQ-020 Leading-zero blank: when index 0 is active and hour_h = 0, SEG SHALL be 1111111.
REQ-021 DP SHALL be 0 on digits 1 and 3 (separators) and 1 on all other digits.
REQ-022 An 8-bit frame counter SHALL increment on each frame_tick and wrap 255→0; blink phase = frame counter[BLINK_BIT].
REQ-023 When blink phase = 1 and the active digit belongs to the field chosen by blink_sel, SEG SHALL be 1111111 and DP SHALL be 1; AN is unaffected.
REQ-024 Blink fields SHALL be: hours = digits 0–1, minutes = digits 2–3, seconds = digits 4–5.
REQ-025 EN=0 SHALL freeze the prescaler, index and frame counter; outputs keep tracking the frozen digit, and no frame_tick is issued.
REQ-026 When EN returns to 1, counting SHALL resume from the frozen prescaler value; there is no restart.
REQ-027 With SCAN_DIV=1, a step SHALL occur on every enabled cycle.
REQ-028 A blink_sel change SHALL take effect on the next registered output update.

Reset
REQ-029 nCR=0 SHALL immediately (asynchronously) force:
- prescaler = 0, index = 0, frame counter = 0
- AN = 111111, SEG = 1111111, DP = 1, frame_tick = 0
REQ-030 On the first CP edge after nCR rises, outputs SHALL show digit 0 (AN = 111110).
REQ-031 Reset asserted mid-scan SHALL abort the scan with no partial-step artefacts; on release, scanning restarts at digit 0 with a full SCAN_DIV dwell.

Verification
REQ-032 Reset: hold nCR=0 with CP toggling → AN = 111111, SEG = 1111111, DP = 1, frame_tick = 0 throughout.
REQ-033 Scan sequence: SCAN_DIV=4, time 12:34:56, EN=1.
- AN steps 111110, 111101, …, 011111, holding each value 4 cycles.
- SEG shows 1111001 on digit 0, 0100100 on digit 1, 0010010 on digit 4.
- DP = 0 on digits 1 and 3 only.
- frame_tick fires once per 24 cycles.
REQ-034 Blank and dash:
- hour_h = 0 → SEG = 1111111 while AN = 111110.
- sec_l = 4'hC → SEG = 0111111 on digit 5.
REQ-035 Blink: SCAN_DIV=2, BLINK_BIT=0, blink_sel=2 → digits 2–3 show 1111111 with DP = 1 on odd frames and normal values on even frames; other digits are unaffected.
REQ-036 Enable hold: drop EN mid-dwell on digit 3 for 10 cycles → AN stays 110111 and no frame_tick; after EN rises, the remaining dwell completes before digit 4.
REQ-037 Mid-scan reset: pulse nCR low asynchronously, between CP edges, during digit 4 → outputs reach reset values before the next edge; after release, AN = 111110 with a full 4-cycle dwell.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS clock.
// Active-low digit enables and segments, blinking field, leading-hour blank.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_BIT = 5
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       EN,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    input  logic [1:0] blink_sel,
    output logic [5:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [7:0]    r_frame;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_tick;

    logic          w_step;
    logic          w_wrap;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic [1:0]    w_field;
    logic          w_blink;
    logic          w_sep;
    logic [5:0]    w_an_next;

    assign w_step = EN && (r_presc == PW'(SCAN_DIV - 1));
    assign w_wrap = w_step && (r_idx == 3'd5);

    always_comb begin
        w_digit = 4'h0;
        w_field = 2'd0;
        case (r_idx)
            3'd0: begin w_digit = hour_h; w_field = 2'd1; end
            3'd1: begin w_digit = hour_l; w_field = 2'd1; end
            3'd2: begin w_digit = min_h;  w_field = 2'd2; end
            3'd3: begin w_digit = min_l;  w_field = 2'd2; end
            3'd4: begin w_digit = sec_h;  w_field = 2'd3; end
            3'd5: begin w_digit = sec_l;  w_field = 2'd3; end
            default: begin w_digit = 4'h0; w_field = 2'd0; end
        endcase
    end

    // Segment order {g,f,e,d,c,b,a}, low = lit; non-BCD codes show a dash.
    always_comb begin
        w_seg = 7'b0111111;
        case (w_digit)
            4'd0: w_seg = 7'b1000000;
            4'd1: w_seg = 7'b1111001;
            4'd2: w_seg = 7'b0100100;
            4'd3: w_seg = 7'b0110000;
            4'd4: w_seg = 7'b0011001;
            4'd5: w_seg = 7'b0010010;
            4'd6: w_seg = 7'b0000010;
            4'd7: w_seg = 7'b1111000;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0010000;
            default: w_seg = 7'b0111111;
        endcase
        if (r_idx == 3'd0 && hour_h == 4'd0) begin
            w_seg = 7'b1111111;
        end
    end

    assign w_blink = r_frame[BLINK_BIT] && (blink_sel != 2'd0) && (blink_sel == w_field);
    assign w_sep   = (r_idx == 3'd1) || (r_idx == 3'd3);

    for (genvar gi = 0; gi < 6; gi++) begin : g_an
        assign w_an_next[gi] = (r_idx != 3'(gi));
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_presc      <= '0;
            r_idx        <= 3'd0;
            r_frame      <= 8'd0;
            r_an         <= 6'b111111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            if (EN) begin
                r_presc <= w_step ? '0 : r_presc + 1'b1;
            end
            if (w_step) begin
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end
            if (w_wrap) begin
                r_frame <= r_frame + 8'd1;
            end
            r_frame_tick <= w_wrap;
            // Output stage follows the live inputs every cycle, even while frozen.
            r_an  <= w_an_next;
            r_seg <= w_blink ? 7'b1111111 : w_seg;
            r_dp  <= w_blink | ~w_sep;
        end
    end

    assign AN         = r_an;
    assign SEG        = r_seg;
    assign DP         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three instances with different dividers/blink bits
// checked each cycle against an arithmetic model of scan position and frame number.
module tb_seg_scan_driver;

    logic       CP = 1'b0;
    logic       nCR;
    logic       EN;
    logic [3:0] hh, hl, mh, ml, sh, sl;
    logic [1:0] bsel;

    logic [5:0] an_o  [3];
    logic [6:0] seg_o [3];
    logic       dp_o  [3];
    logic       ft_o  [3];

    int divs   [3] = '{4, 2, 1};
    int blinks [3] = '{1, 0, 2};
    int n      [3];

    logic [5:0] exp_an  [3];
    logic [6:0] exp_seg [3];
    logic       exp_dp  [3];
    logic       exp_ft  [3];

    int total = 0;
    int bad   = 0;

    always #5 CP = ~CP;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_BIT(1)) dut0 (
        .CP(CP), .nCR(nCR), .EN(EN),
        .hour_h(hh), .hour_l(hl), .min_h(mh), .min_l(ml), .sec_h(sh), .sec_l(sl),
        .blink_sel(bsel),
        .AN(an_o[0]), .SEG(seg_o[0]), .DP(dp_o[0]), .frame_tick(ft_o[0])
    );

    seg_scan_driver #(.SCAN_DIV(2), .BLINK_BIT(0)) dut1 (
        .CP(CP), .nCR(nCR), .EN(EN),
        .hour_h(hh), .hour_l(hl), .min_h(mh), .min_l(ml), .sec_h(sh), .sec_l(sl),
        .blink_sel(bsel),
        .AN(an_o[1]), .SEG(seg_o[1]), .DP(dp_o[1]), .frame_tick(ft_o[1])
    );

    seg_scan_driver #(.SCAN_DIV(1), .BLINK_BIT(2)) dut2 (
        .CP(CP), .nCR(nCR), .EN(EN),
        .hour_h(hh), .hour_l(hl), .min_h(mh), .min_l(ml), .sec_h(sh), .sec_l(sl),
        .blink_sel(bsel),
        .AN(an_o[2]), .SEG(seg_o[2]), .DP(dp_o[2]), .frame_tick(ft_o[2])
    );

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [3:0] digit_at(input int idx);
        case (idx)
            0: return hh;
            1: return hl;
            2: return mh;
            3: return ml;
            4: return sh;
            default: return sl;
        endcase
    endfunction

    // Model: n = enabled cycles since reset; position and frame follow by division.
    task automatic tick();
        logic [5:0] ea [3];
        logic [6:0] es [3];
        logic       ed [3];
        logic       ef [3];
        int idx, frame, period;
        bit ph, blink;
        for (int k = 0; k < 3; k++) begin
            if (!nCR) begin
                ea[k] = 6'b111111; es[k] = 7'b1111111; ed[k] = 1'b1; ef[k] = 1'b0;
            end else begin
                period = 6 * divs[k];
                idx    = (n[k] / divs[k]) % 6;
                frame  = (n[k] / period) % 256;
                ph     = ((frame >> blinks[k]) & 1) == 1;
                blink  = ph && (bsel != 2'd0) && (int'(bsel) == idx / 2 + 1);
                ea[k]  = ~(6'b000001 << idx);
                if (blink)                      es[k] = 7'b1111111;
                else if (idx == 0 && hh == 4'd0) es[k] = 7'b1111111;
                else                            es[k] = seg_code(digit_at(idx));
                ed[k] = blink ? 1'b1 : ((idx == 1 || idx == 3) ? 1'b0 : 1'b1);
                ef[k] = EN && ((n[k] % period) == period - 1);
            end
        end
        @(posedge CP);
        for (int k = 0; k < 3; k++) begin
            if (!nCR)    n[k] = 0;
            else if (EN) n[k] = n[k] + 1;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_an[k] = ea[k]; exp_seg[k] = es[k]; exp_dp[k] = ed[k]; exp_ft[k] = ef[k];
        end
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        hh = a; hl = b; mh = c; ml = d; sh = e; sl = f;
    endtask

    task automatic test_reset();
        int errs = 0;
        nCR = 1'b0; EN = 1'b1; bsel = 2'd0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        for (int k = 0; k < 3; k++) n[k] = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== 6'b111111 || seg_o[k] !== 7'b1111111 || dp_o[k] !== 1'b1 || ft_o[k] !== 1'b0) begin
                    bad++; errs++;
                    $display("FAIL reset inst%0d: AN=%b SEG=%b DP=%b FT=%b want AN=111111 SEG=1111111 DP=1 FT=0",
                             k, an_o[k], seg_o[k], dp_o[k], ft_o[k]);
                end
            end
        end
        nCR = 1'b1;
        $display("test_reset: errors=%0d", errs);
    endtask

    task automatic test_scan();
        int errs = 0;
        int ticks0 = 0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        for (int c = 0; c < 48; c++) begin
            tick();
            if (ft_o[0] === 1'b1) ticks0++;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || dp_o[k] !== exp_dp[k] || ft_o[k] !== exp_ft[k]) begin
                    bad++; errs++;
                    $display("FAIL scan inst%0d cyc%0d: AN=%b SEG=%b DP=%b FT=%b want AN=%b SEG=%b DP=%b FT=%b",
                             k, c, an_o[k], seg_o[k], dp_o[k], ft_o[k], exp_an[k], exp_seg[k], exp_dp[k], exp_ft[k]);
                end
            end
        end
        total++;
        if (ticks0 !== 2) begin
            bad++; errs++;
            $display("FAIL scan_frame_ticks: got %0d want 2", ticks0);
        end
        $display("test_scan: errors=%0d", errs);
    endtask

    task automatic test_blank_dash();
        int errs = 0;
        set_time(4'd0, 4'd9, 4'd5, 4'd8, 4'd0, 4'hC);
        for (int c = 0; c < 30; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || dp_o[k] !== exp_dp[k] || ft_o[k] !== exp_ft[k]) begin
                    bad++; errs++;
                    $display("FAIL blank_dash inst%0d cyc%0d: AN=%b SEG=%b DP=%b want AN=%b SEG=%b DP=%b",
                             k, c, an_o[k], seg_o[k], dp_o[k], exp_an[k], exp_seg[k], exp_dp[k]);
                end
            end
            if (an_o[0] === 6'b111110) begin
                total++;
                if (seg_o[0] !== 7'b1111111) begin
                    bad++; errs++;
                    $display("FAIL leading_blank: SEG=%b want 1111111", seg_o[0]);
                end
            end
            if (an_o[0] === 6'b011111) begin
                total++;
                if (seg_o[0] !== 7'b0111111) begin
                    bad++; errs++;
                    $display("FAIL dash: SEG=%b want 0111111", seg_o[0]);
                end
            end
        end
        $display("test_blank_dash: errors=%0d", errs);
    endtask

    task automatic test_blink();
        int errs = 0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        bsel = 2'd2;
        for (int c = 0; c < 120; c++) begin
            if (c >= 60) bsel = 2'($urandom_range(0, 3));
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || dp_o[k] !== exp_dp[k] || ft_o[k] !== exp_ft[k]) begin
                    bad++; errs++;
                    $display("FAIL blink inst%0d cyc%0d sel=%0d: AN=%b SEG=%b DP=%b want AN=%b SEG=%b DP=%b",
                             k, c, bsel, an_o[k], seg_o[k], dp_o[k], exp_an[k], exp_seg[k], exp_dp[k]);
                end
            end
        end
        bsel = 2'd0;
        $display("test_blink: errors=%0d", errs);
    endtask

    task automatic test_enable_hold();
        int errs = 0;
        int waited = 0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        EN = 1'b1;
        while (exp_an[0] !== 6'b110111 && waited < 100) begin
            tick(); waited++;
        end
        total++;
        if (waited >= 100) begin
            bad++; errs++;
            $display("FAIL hold_wait: digit 3 not reached, AN=%b", an_o[0]);
        end
        tick();
        EN = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || dp_o[k] !== exp_dp[k] || ft_o[k] !== exp_ft[k]) begin
                    bad++; errs++;
                    $display("FAIL hold inst%0d cyc%0d: AN=%b FT=%b want AN=%b FT=%b", k, c, an_o[k], ft_o[k], exp_an[k], exp_ft[k]);
                end
            end
            total++;
            if (an_o[0] !== 6'b110111 || ft_o[0] !== 1'b0) begin
                bad++; errs++;
                $display("FAIL hold_frozen: AN=%b FT=%b want AN=110111 FT=0", an_o[0], ft_o[0]);
            end
        end
        EN = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || dp_o[k] !== exp_dp[k] || ft_o[k] !== exp_ft[k]) begin
                    bad++; errs++;
                    $display("FAIL resume inst%0d cyc%0d: AN=%b want %b", k, c, an_o[k], exp_an[k]);
                end
            end
        end
        $display("test_enable_hold: errors=%0d", errs);
    endtask

    task automatic test_midscan_reset();
        int errs = 0;
        int waited = 0;
        int dwell = 0;
        while (exp_an[0] !== 6'b101111 && waited < 100) begin
            tick(); waited++;
        end
        total++;
        if (waited >= 100) begin
            bad++; errs++;
            $display("FAIL mreset_wait: digit 4 not reached, AN=%b", an_o[0]);
        end
        #1 nCR = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (an_o[k] !== 6'b111111 || seg_o[k] !== 7'b1111111 || dp_o[k] !== 1'b1 || ft_o[k] !== 1'b0) begin
                bad++; errs++;
                $display("FAIL mreset_async inst%0d: AN=%b SEG=%b DP=%b FT=%b", k, an_o[k], seg_o[k], dp_o[k], ft_o[k]);
            end
            n[k] = 0;
        end
        #1 nCR = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c < 5 && an_o[0] === 6'b111110) dwell++;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || dp_o[k] !== exp_dp[k] || ft_o[k] !== exp_ft[k]) begin
                    bad++; errs++;
                    $display("FAIL mreset inst%0d cyc%0d: AN=%b want %b", k, c, an_o[k], exp_an[k]);
                end
            end
        end
        total++;
        if (dwell !== 4) begin
            bad++; errs++;
            $display("FAIL mreset_dwell: digit0 cycles=%0d want 4", dwell);
        end
        $display("test_midscan_reset: errors=%0d", errs);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 2500; c++) begin
            EN   = ($urandom_range(0, 9) < 8);
            bsel = 2'($urandom_range(0, 3));
            set_time(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || dp_o[k] !== exp_dp[k] || ft_o[k] !== exp_ft[k]) begin
                    bad++; errs++;
                    $display("FAIL random inst%0d cyc%0d: AN=%b SEG=%b DP=%b FT=%b want AN=%b SEG=%b DP=%b FT=%b",
                             k, c, an_o[k], seg_o[k], dp_o[k], ft_o[k], exp_an[k], exp_seg[k], exp_dp[k], exp_ft[k]);
                end
            end
        end
        EN = 1'b1;
        $display("test_random: errors=%0d", errs);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_dash();
        test_blink();
        test_enable_hold();
        test_midscan_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
